// File: rtl/fsm_trace_buffer_if.sv
// rtl/fsm_trace_buffer_if.sv - trace entry output stream between buffer and consumer
interface fsm_trace_buffer_if;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;

  modport master (output out_valid, output out_data, input out_ready);
  modport slave  (input out_valid, input out_data, output out_ready);
endinterface

// File: rtl/fsm_trace_buffer.sv
// rtl/fsm_trace_buffer.sv - records FSM state transitions in a FIFO, counts S0 entries, flags stuck states
module fsm_trace_buffer #(
  parameter int DEPTH       = 8,
  parameter int STUCK_LIMIT = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [3:0]               state_in,
  input  logic                     clr_stats,
  fsm_trace_buffer_if.master       out_if,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic [7:0]               loop_count,
  output logic                     stuck
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int DW = $clog2(STUCK_LIMIT + 1);

  logic [3:0]    prev_q;
  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic [7:0]    loop_q, loop_d;
  logic [DW-1:0] dwell_q, dwell_d;

  logic transition, pop, full, push, drop;

  always_comb begin
    transition = (state_in != prev_q);
    pop        = (count_q != '0) && out_if.out_ready;
    full       = (count_q == CW'(DEPTH));
    // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
    push       = transition && (!full || pop);
    drop       = transition && full && !pop;
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    overflow_d = overflow_q;
    loop_d     = loop_q;
    dwell_d    = dwell_q;
    if (clr_stats) begin
      overflow_d = 1'b0;
      loop_d     = '0;
      dwell_d    = '0;
    end else begin
      if (drop)
        overflow_d = 1'b1;
      if (transition && state_in == 4'b0000)
        loop_d = loop_q + 8'd1;
      if (transition)
        dwell_d = '0;
      else if (dwell_q != DW'(STUCK_LIMIT))
        dwell_d = dwell_q + DW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q     <= 4'b0000;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      loop_q     <= '0;
      dwell_q    <= '0;
    end else begin
      prev_q     <= state_in;
      if (push)
        wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)
        rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q    <= count_d;
      overflow_q <= overflow_d;
      loop_q     <= loop_d;
      dwell_q    <= dwell_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && push)
      mem_q[wr_ptr_q] <= {prev_q, state_in};
  end

  assign out_if.out_valid = (count_q != '0);
  assign out_if.out_data  = mem_q[rd_ptr_q];
  assign count            = count_q;
  assign overflow         = overflow_q;
  assign loop_count       = loop_q;
  assign stuck            = (dwell_q == DW'(STUCK_LIMIT));

endmodule

// File: doc/fsm_trace_buffer.md
FSM_TRACE_BUFFER -- requirements
Module: fsm_trace_buffer

Interface
REQ-001 Parameter DEPTH, 8, number of FIFO entries; power of two, at least 2.
REQ-002 Parameter STUCK_LIMIT, 16, number of consecutive unchanged samples that raises stuck; at least 2.
REQ-003 Port clk  input  1  rising-edge clock.
REQ-004 Port reset  input  1  reset; synchronous, active-high.
REQ-005 Port state_in  input  4  state code from the upstream 16-state FSM, sampled every clk edge.
REQ-006 Port clr_stats  input  1  synchronous clear of overflow, loop_count and dwell.
REQ-007 Port out_ready  input  1  consumer accepts the head entry.
REQ-008 Port out_valid  output  1  FIFO holds at least one entry.
REQ-009 Port out_data  output  8  head entry; [7:4] = previous state, [3:0] = new state.
REQ-010 Port count  output  $clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH.
REQ-011 Port overflow  output  1  sticky flag: a transition was dropped.
REQ-012 Port loop_count  output  8  number of entries into S0.
REQ-013 Port stuck  output  1  state unchanged for STUCK_LIMIT samples.

Function
REQ-014 Internal register prev_state shall hold the state_in sampled at the previous edge.
REQ-015 Each non-reset edge: a transition is state_in != prev_state; prev_state <= state_in on every edge.
REQ-016 On a transition, entry {prev_state, state_in} shall be pushed at that edge, so out_valid/out_data reflect it one cycle after sampling.
REQ-017 Push when the FIFO is full and no pop occurs in the same cycle: entry dropped, FIFO unchanged, overflow <= 1.
REQ-018 Pop occurs at an edge where out_valid & out_ready; the head advances and count decrements.
REQ-019 Push and pop in the same cycle shall both take effect; count stays unchanged; no overflow, including when full.
REQ-020 out_ready while empty shall have no effect; count shall never go below 0.
REQ-021 Read and write pointers shall wrap modulo DEPTH; entries shall leave in push order.
REQ-022 out_data shall be stable while out_valid=1 and out_ready=0.
REQ-023 loop_count shall increment on each transition whose new state is 4'b0000, and shall wrap from 255 to 0.
REQ-024 Dwell counter behaviour:
- cleared to 0 on a transition;
- otherwise incremented by 1 per edge, saturating at STUCK_LIMIT.
REQ-025 stuck shall equal (dwell == STUCK_LIMIT) and shall deassert the cycle after the next transition.
REQ-026 clr_stats=1 shall clear overflow, loop_count and dwell at that edge; FIFO contents and prev_state are unaffected.
REQ-027 clr_stats coinciding with an overflow or S0-entry event: the clear wins and the event is not counted.
REQ-028 Transitions shall be pushed into the FIFO during clr_stats.

Reset
REQ-029 reset=1 at an edge shall set:
- prev_state = 0, FIFO empty, count = 0, out_valid = 0;
- overflow = 0, loop_count = 0, dwell = 0, stuck = 0.
REQ-030 Reset shall take priority over clr_stats, push and pop.
REQ-031 Reset mid-operation shall discard all stored entries; no transition is recorded at the reset edge itself.

Verification
REQ-032 Single transition: after reset, state_in 0->1 with out_ready=0 -> next cycle out_valid=1, out_data=8'h01, count=1.
REQ-033 Full FIFO and overflow:
- stimulus: with DEPTH=8 and out_ready=0, drive 9 distinct transitions;
- response: count=8 and overflow=1; out_data=first entry.
REQ-034 Full with simultaneous push and pop: FIFO full, out_ready=1 plus one transition -> count stays 8, overflow stays 0, pushed entry appears last.
REQ-035 Loop count: sequence 0->2->6->14->15->0 repeated 256 times -> loop_count returns to 0; clr_stats mid-run -> loop_count=0 next cycle.
REQ-036 Stuck detection:
- hold state_in=14 for 16 edges after entering it -> stuck=1;
- change to 13 -> stuck=0 the following cycle.
REQ-037 Reset mid-operation: reset asserted with count=5 and overflow=1 -> next cycle count=0, out_valid=0, overflow=0.
